fc_layer_ctrl: RTL

Sequencer for the binary-weight fully-connected datapath, which has 16 lanes of 9-bit features, a 16-bit weight word and a 13-bit sum.
- Latches one 16-feature vector from the maxpool stage.
- Fetches one 16-bit binary weight word per output neuron from weight memory.
- Holds the datapath inputs stable for the datapath's settle latency, captures each neuron sum and emits it over a valid/ready handshake.
- Tracks a running argmax, which gives the final classification.

---
 rtl/fc_layer_ctrl_if.sv | 21 ++
 rtl/fc_layer_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/fc_layer_ctrl_if.sv
// Weight-memory read port and per-neuron result handshake of the FC layer sequencer.
interface fc_layer_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              wt_rd_en;
    logic [ADDR_W-1:0] wt_addr;
    logic [15:0]       wt_rdata;
    logic              res_valid;
    logic              res_ready;
    logic [12:0]       res_data;
    logic [ADDR_W-1:0] res_idx;

    modport master (
        output wt_rd_en, output wt_addr, input wt_rdata,
        output res_valid, input res_ready, output res_data, output res_idx
    );
    modport slave (
        input wt_rd_en, input wt_addr, output wt_rdata,
        input res_valid, output res_ready, input res_data, input res_idx
    );
endinterface

// File: rtl/fc_layer_ctrl.sv
// Sequencer for the binary-weight FC datapath: latches features, walks the weight words,
// waits out the datapath latency, emits each neuron sum and tracks the running argmax.
module fc_layer_ctrl #(
    parameter  int NUM_NEURONS = 10,
    parameter  int ADDR_W      = 4,
    parameter  int FC_LAT      = 10,
    localparam int NUM_LANES   = 16,
    localparam int VEC_W       = 9,
    localparam int WT_W        = 16,
    localparam int SUM_W       = 13
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [NUM_LANES-1:0][VEC_W-1:0]   feat_in,
    fc_layer_ctrl_if.master                   bus,
    output logic [NUM_LANES-1:0][VEC_W-1:0]   fc_feat,
    output logic [WT_W-1:0]                   fc_bw,
    input  logic [SUM_W-1:0]                  fc_out,
    output logic                              busy,
    output logic                              done,
    output logic [ADDR_W-1:0]                 class_idx,
    output logic [SUM_W-1:0]                  class_score
);
    localparam int CNT_W = $clog2(FC_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_WAIT, S_EMIT, S_DONE
    } state_t;

    state_t             state, state_nx;
    logic [ADDR_W-1:0]  n;
    logic [CNT_W-1:0]   cnt;
    logic [SUM_W-1:0]   res_data_q;
    logic [ADDR_W-1:0]  res_idx_q;
    logic               wait_last;
    logic               last_n;
    logic               take;
    logic               better;

    assign wait_last = (cnt == CNT_W'(FC_LAT));
    assign last_n    = (n == ADDR_W'(NUM_NEURONS - 1));
    assign take      = (state == S_EMIT) && bus.res_ready;
    // Strictly greater keeps the lower index on ties; neuron 0 always seeds the argmax.
    assign better    = (n == '0) || ($signed(res_data_q) > $signed(class_score));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        busy          = (state != S_IDLE);
        done          = (state == S_DONE);
        bus.wt_rd_en  = (state == S_FETCH);
        bus.res_valid = (state == S_EMIT);
        case (state)
            S_IDLE:  if (start) state_nx = S_FETCH;
            S_FETCH: state_nx = S_LOAD;
            S_LOAD:  state_nx = S_WAIT;
            S_WAIT:  if (wait_last) state_nx = S_EMIT;
            S_EMIT:  if (bus.res_ready) state_nx = last_n ? S_DONE : S_FETCH;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // The neuron index doubles as the weight address, so it holds outside FETCH.
    assign bus.wt_addr  = n;
    assign bus.res_data = res_data_q;
    assign bus.res_idx  = res_idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n           <= '0;
            cnt         <= '0;
            fc_feat     <= '0;
            fc_bw       <= '0;
            res_data_q  <= '0;
            res_idx_q   <= '0;
            class_idx   <= '0;
            class_score <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    fc_feat     <= feat_in;
                    n           <= '0;
                    class_idx   <= '0;
                    class_score <= '0;
                end
                S_LOAD: begin
                    fc_bw <= bus.wt_rdata;
                    cnt   <= '0;
                end
                // FC_LAT+1 cycles here leaves one cycle of margin past the settle latency.
                S_WAIT: begin
                    if (wait_last) begin
                        res_data_q <= fc_out;
                        res_idx_q  <= n;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_EMIT: if (take) begin
                    if (better) begin
                        class_idx   <= res_idx_q;
                        class_score <= res_data_q;
                    end
                    if (!last_n) n <= n + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
